alu_uart_sequencer: RTL
=======================

Name: alu_uart_sequencer

Overview:
Sequences the shared ALU datapath from a UART byte stream. It collects operand A, operand B and the opcode as three consecutive received bytes and drives them onto the ALU inputs. It captures the ALU result and hands it to the UART transmitter as a single byte. It sits between the UART rx/tx cores and the combinational ALU, and replaces the button/switch loading path in the board top level.

Parameters:
DATA_W, 8, operand/result width (one UART byte)
OP_W, 6, ALU opcode width; taken from the low OP_W bits of the opcode byte
TIMEOUT_CYCLES, 50_000_000, max idle clocks allowed between bytes of one transaction
VALIDATE_OP, 1, 1 = reject opcodes outside the supported set

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_rx_done  in  1  one-cycle pulse: i_rx_data valid
i_rx_data  in  DATA_W  received byte
i_tx_done  in  1  one-cycle pulse: transmitter finished the byte
o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
o_tx_data  out  DATA_W  byte to transmit (registered result)
o_alu_a  out  DATA_W  operand A to ALU (registered)
o_alu_b  out  DATA_W  operand B to ALU (registered)
o_alu_op  out  OP_W  opcode to ALU (registered)
i_alu_result  in  DATA_W  combinational ALU result
o_busy  out  1  high in every state except IDLE
o_err  out  1  one-cycle pulse on timeout or invalid opcode
o_drop  out  1  one-cycle pulse when a received byte is discarded

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous, active-high, on i_reset, sampled only on the rising edge of i_clk.
- Reset state: FSM in IDLE; all registered outputs 0 (o_alu_a/b/op, o_tx_data, o_tx_start, o_busy, o_err, o_drop); timeout counter 0.
- Reset mid-transaction: aborts the transaction; o_tx_start is low on the cycle after reset; a pending tx_done is ignored.
- FSM states and transitions:
  - IDLE: on i_rx_done, load o_alu_a, go to GET_B.
  - GET_B: on i_rx_done, load o_alu_b, go to GET_OP.
  - GET_OP: on i_rx_done, load o_alu_op = i_rx_data[OP_W-1:0], go to EXEC.
  - EXEC: one cycle with the operands stable. If the op is valid, capture i_alu_result into o_tx_data and go to SEND. If the op is invalid (VALIDATE_OP=1), pulse o_err and go to IDLE.
  - SEND: o_tx_start=1 for exactly this cycle, then go to WAIT_TX.
  - WAIT_TX: wait for i_tx_done, then go to IDLE.
- Latency: final rx_done accepted at edge n -> EXEC during cycle n+1 -> o_tx_start high during cycle n+2 with o_tx_data already valid.
- Supported opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010. Bits [7:6] of the opcode byte are ignored.
- Timeout:
  - Counter clears on every accepted byte and while in IDLE, SEND or WAIT_TX.
  - It increments in GET_B and GET_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_done, the FSM goes to IDLE and pulses o_err. Operand registers keep their values.
  - Simultaneous rx_done and expiry: the byte wins, is accepted and the counter clears.
- Drops: i_rx_done in EXEC, SEND or WAIT_TX discards the byte and pulses o_drop; the FSM state is unchanged.
- Stray tx_done: i_tx_done outside WAIT_TX is ignored.
- Output hold: o_alu_a/b/op and o_tx_data hold their last values until overwritten; there is no clearing on return to IDLE.
- Width rules: no arithmetic is performed in this block. The result is taken as DATA_W bits from the ALU unchanged.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W and OP_W defaults
  - opcode localparams (OP_ADD ... OP_SRL)
  - FSM state encoding: IDLE, GET_B, GET_OP, EXEC, SEND, WAIT_TX
- One sub-module, alu_op_check: combinational, input OP_W opcode, output o_valid. It is instantiated only when VALIDATE_OP=1; otherwise valid is tied to 1.
- The timeout counter stays inline.

Test Plan:
- Reset, then bytes 0x08, 0x04, 0x20 (ADD) with a bench ALU model -> o_alu_a=0x08, o_alu_b=0x04, o_alu_op=6'b100000. o_tx_start pulses 2 cycles after the third rx_done with o_tx_data=0x0C. After i_tx_done, o_busy=0.
- Bytes 0x08, 0x04, 0x27 (NOR) -> o_tx_data=0xF3; a second transaction 0xF0, 0x0F, 0x26 (XOR) -> 0xFF, with no residue from the first.
- Bytes 0x01, 0x02, 0x3F (invalid) -> o_err pulses 1 cycle in EXEC, no o_tx_start, FSM back in IDLE. The next valid triple still works.
- TIMEOUT_CYCLES=16: send 0x05, then idle 16 cycles -> o_err pulse, FSM in IDLE. Repeat with rx_done on exactly the expiry cycle -> byte accepted as B, no o_err.
- i_rx_done with 0xAA during WAIT_TX -> o_drop pulse; state and o_tx_data unchanged; tx_done -> IDLE. A stray i_tx_done in IDLE has no effect.
- Assert i_reset in GET_OP and again in WAIT_TX -> next cycle all outputs 0, FSM in IDLE, no o_tx_start.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU opcodes and sequencer state encoding
package alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        IDLE,
        GET_B,
        GET_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

endpackage

// File: rtl/alu_op_check.sv
// rtl/alu_op_check.sv - flags whether an opcode belongs to the supported ALU set
module alu_op_check
    import alu_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic [OP_W-1:0] i_op,
    output logic            o_valid
);

    always_comb begin
        o_valid = 1'b0;
        case (i_op)
            OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND), OP_W'(OP_OR),
            OP_W'(OP_XOR), OP_W'(OP_NOR), OP_W'(OP_SRA), OP_W'(OP_SRL):
                o_valid = 1'b1;
            default:
                o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// rtl/alu_uart_sequencer.sv - collects A, B, opcode from UART rx, runs the ALU, sends the result byte
module alu_uart_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int OP_W           = OP_W_DEF,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int VALIDATE_OP    = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_tx_done,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx_data,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_drop
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_op_valid;
    logic             w_waiting;
    logic             w_expire;

    generate
        if (VALIDATE_OP != 0) begin : g_check
            alu_op_check #(.OP_W(OP_W)) u_op_check (
                .i_op    (o_alu_op),
                .o_valid (w_op_valid)
            );
        end else begin : g_nocheck
            assign w_op_valid = 1'b1;
        end
    endgenerate

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_waiting = (r_state == GET_B) || (r_state == GET_OP);
    assign w_expire  = w_waiting && !i_rx_done && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_rx_done) w_next = GET_B;
            GET_B:   if (i_rx_done) w_next = GET_OP;
                     else if (w_expire) w_next = IDLE;
            GET_OP:  if (i_rx_done) w_next = EXEC;
                     else if (w_expire) w_next = IDLE;
            EXEC:    w_next = w_op_valid ? SEND : IDLE;
            SEND:    w_next = WAIT_TX;
            WAIT_TX: if (i_tx_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_waiting && !i_rx_done && !w_expire)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
            if (i_rx_done) begin
                case (r_state)
                    IDLE:    o_alu_a  <= i_rx_data;
                    GET_B:   o_alu_b  <= i_rx_data;
                    GET_OP:  o_alu_op <= i_rx_data[OP_W-1:0];
                    default: ;
                endcase
            end
            if (r_state == EXEC && w_op_valid)
                o_tx_data <= i_alu_result;
        end
    end

    assign o_busy     = (r_state != IDLE);
    assign o_tx_start = (r_state == SEND);
    assign o_err      = ((r_state == EXEC) && !w_op_valid) || w_expire;
    assign o_drop     = i_rx_done && ((r_state == EXEC) || (r_state == SEND) || (r_state == WAIT_TX));

endmodule
